// File: rtl/sobel_pkg.sv
// Shared types and geometry constants for the sobel frame sequencer.
package sobel_pkg;

    localparam int PIXELS_PER_BEAT = 16;
    localparam int BEATS_PER_LINE  = 4;
    localparam int LINE_W          = 512;
    localparam int BEAT_W          = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } sobel_ctrl_state_t;

endpackage

// File: rtl/sobel_frame_ctrl_chk.sv
// Simulation checker: sobel_unit must only answer beats that were issued.
module sobel_frame_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic su_valid_out,
    input logic inflight
);

    a_no_orphan_result: assert property (@(posedge clk) disable iff (rst)
        (su_valid_out |-> inflight));

endmodule

// File: rtl/sobel_out_skid2.sv
// Two-entry result buffer between the sobel_unit output and the write path.
// Holds {last, data}; a push and a pop in the same cycle keep the count and
// the order. The head entry is never overwritten while it is still presented.
module sobel_out_skid2 #(
    parameter int W = 513
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         pop,
    output logic [1:0]   count
);

    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push_ok_s;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = rd_ptr_q ? ent1_q : ent0_q;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        ent0_d    = ent0_q;
        ent1_d    = ent1_q;
        push_ok_s = push & ((count_q != 2'd2) | pop);
        if (push_ok_s) begin
            if (wr_ptr_q) begin
                ent1_d = push_data;
            end else begin
                ent0_d = push_data;
            end
            wr_ptr_d = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Buffer state registers; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q   <= {W{1'b0}};
            ent1_q   <= {W{1'b0}};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            ent0_q   <= ent0_d;
            ent1_q   <= ent1_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for sobel_unit: slices 512-bit lines into 128-bit beats,
// resets the unit's row buffers at frame start, drops the two priming rows
// and buffers kept results with backpressure toward the write path.
// Optional build macro SOBEL_CTRL_PERF_EN adds stall/starve counters.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int ROW_PIXELS = 512,
    parameter int ROWS_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROWS_W-1:0] cfg_rows,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              in_valid,
    input  logic [LINE_W-1:0] in_data,
    output logic              in_ready,
    output logic              su_rst_b,
    output logic              su_valid,
    output logic [BEAT_W-1:0] su_data,
    input  logic              su_valid_out,
    input  logic [LINE_W-1:0] su_result,
    output logic              out_valid,
    output logic [LINE_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready
`ifdef SOBEL_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_starve
`endif
);

    localparam int BEATS_PER_ROW = ROW_PIXELS / PIXELS_PER_BEAT;
    localparam int BR_W          = $clog2(BEATS_PER_ROW);
    localparam int CNT_W         = ROWS_W + BR_W;

    sobel_ctrl_state_t state_q, state_d;
    logic [ROWS_W-1:0] rows_q, rows_d;
    logic [BR_W-1:0]   beat_row_q, beat_row_d;
    logic [CNT_W-1:0]  row_cnt_q, row_cnt_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              line_full_q, line_full_d;
    logic              inflight_q, inflight_d;
    logic              keep_q, keep_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              su_rst_b_q, su_rst_b_d;

    logic              issue_s, accept_s, beat_last_s, final_beat_s, rows_ok_s;
    logic [1:0]        sub_s, skid_count_s;
    logic              pop_s, push_s;
    logic [LINE_W:0]   skid_out_s;

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign su_rst_b = su_rst_b_q;
    assign su_valid = issue_s;
    assign out_data = skid_out_s[LINE_W-1:0];
    assign out_last = out_valid & skid_out_s[LINE_W];
    assign push_s   = su_valid_out & inflight_q & keep_q;

    // Issue decision, beat slicing and line-register handshake.
    always_comb begin
        sub_s        = beat_row_q[1:0];
        rows_ok_s    = (cfg_rows >= ROWS_W'(3));
        beat_last_s  = (beat_row_q == BR_W'(BEATS_PER_ROW - 1));
        final_beat_s = beat_last_s & (row_cnt_q == (CNT_W'(rows_q) - CNT_W'(1)));
        // A beat in flight may still land in the buffer, so it counts as occupied.
        issue_s      = (state_q == RUN) & line_full_q &
                       (({1'b0, skid_count_s} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_s}));
        in_ready     = (state_q == RUN) &
                       (~line_full_q | (issue_s & (sub_s == 2'd3) & ~final_beat_s));
        accept_s     = in_valid & in_ready;
        if (issue_s) begin
            case (sub_s)
                2'd0:    su_data = line_q[127:0];
                2'd1:    su_data = line_q[255:128];
                2'd2:    su_data = line_q[383:256];
                2'd3:    su_data = line_q[511:384];
                default: su_data = {BEAT_W{1'b0}};
            endcase
        end else begin
            su_data = {BEAT_W{1'b0}};
        end
    end

    // Frame FSM next state, beat/row counters and status flags.
    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        beat_row_d = beat_row_q;
        row_cnt_d  = row_cnt_q;
        err_d      = err_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (rows_ok_s) begin
                        state_d = CLEAR;
                        rows_d  = cfg_rows;
                        err_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                state_d    = RUN;
                beat_row_d = {BR_W{1'b0}};
                row_cnt_d  = {CNT_W{1'b0}};
            end
            RUN: begin
                if (issue_s) begin
                    if (beat_last_s) begin
                        beat_row_d = {BR_W{1'b0}};
                        row_cnt_d  = row_cnt_q + CNT_W'(1);
                    end else begin
                        beat_row_d = beat_row_q + BR_W'(1);
                    end
                    if (final_beat_s) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (~inflight_q & (skid_count_s == 2'd0)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line register fill/drain and the result-side pipeline bits.
    always_comb begin
        if (accept_s) begin
            line_d      = in_data;
            line_full_d = 1'b1;
        end else if (issue_s & (sub_s == 2'd3)) begin
            line_d      = line_q;
            line_full_d = 1'b0;
        end else begin
            line_d      = line_q;
            line_full_d = line_full_q;
        end
        inflight_d = issue_s;
        keep_d     = issue_s & (row_cnt_q >= CNT_W'(2));
        last_d     = issue_s & final_beat_s;
        busy_d     = (state_d != IDLE);
        su_rst_b_d = (state_d != CLEAR);
    end

    // Controller registers; reset abandons any frame without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rows_q      <= {ROWS_W{1'b0}};
            beat_row_q  <= {BR_W{1'b0}};
            row_cnt_q   <= {CNT_W{1'b0}};
            line_q      <= {LINE_W{1'b0}};
            line_full_q <= 1'b0;
            inflight_q  <= 1'b0;
            keep_q      <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            su_rst_b_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            beat_row_q  <= beat_row_d;
            row_cnt_q   <= row_cnt_d;
            line_q      <= line_d;
            line_full_q <= line_full_d;
            inflight_q  <= inflight_d;
            keep_q      <= keep_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            su_rst_b_q  <= su_rst_b_d;
        end
    end

    sobel_out_skid2 #(.W(LINE_W + 1)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data ({last_q, su_result}),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (skid_out_s),
        .pop       (pop_s),
        .count     (skid_count_s)
    );

    sobel_frame_ctrl_chk u_chk (
        .clk          (clk),
        .rst          (rst),
        .su_valid_out (su_valid_out),
        .inflight     (inflight_q)
    );

`ifdef SOBEL_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_starve_q, perf_starve_d;

    assign perf_stall  = perf_stall_q;
    assign perf_starve = perf_starve_q;

    // Saturating stall/starve counters, cleared when a start is taken.
    always_comb begin
        if ((state_q == IDLE) & start) begin
            perf_stall_d  = 32'd0;
            perf_starve_d = 32'd0;
        end else begin
            if ((state_q == RUN) & line_full_q & ~issue_s & (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end else begin
                perf_stall_d = perf_stall_q;
            end
            if ((state_q == RUN) & ~line_full_q & ~in_valid & (perf_starve_q != 32'hFFFF_FFFF)) begin
                perf_starve_d = perf_starve_q + 32'd1;
            end else begin
                perf_starve_d = perf_starve_q;
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q  <= 32'd0;
            perf_starve_q <= 32'd0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_starve_q <= perf_starve_d;
        end
    end
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl: table of frame configurations with
// hand-computed line/beat/output counts, a one-cycle sobel_unit stand-in
// (result = 4 copies of data XOR previous beat), and hand sequences for
// reset behaviour and a reset in the middle of a frame.
module tb_sobel_frame_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  cfg_rows;
    logic         busy, done, err;
    logic         in_valid;
    logic [511:0] in_data;
    logic         in_ready;
    logic         su_rst_b, su_valid;
    logic [127:0] su_data;
    logic         su_valid_out = 1'b0;
    logic [511:0] su_result = '0;
    logic [127:0] stub_prev = '0;
    logic         out_valid;
    logic [511:0] out_data;
    logic         out_last;
    logic         out_ready;
`ifdef SOBEL_CTRL_PERF_EN
    logic [31:0]  perf_stall, perf_starve;
`endif

    typedef struct {
        int rows;
        int rdy_mode;
        int iv_mode;
        bit cpx;
        int exp_lines;
        int exp_beats;
        int exp_outs;
        bit exp_err;
    } vec_t;

    vec_t vecs [7];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sobel_frame_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_rows     (cfg_rows),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .su_rst_b     (su_rst_b),
        .su_valid     (su_valid),
        .su_data      (su_data),
        .su_valid_out (su_valid_out),
        .su_result    (su_result),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready)
`ifdef SOBEL_CTRL_PERF_EN
        ,
        .perf_stall   (perf_stall),
        .perf_starve  (perf_starve)
`endif
    );

    // sobel_unit stand-in: one-cycle latency, held in reset by su_rst_b or rst.
    always @(posedge clk) begin
        su_valid_out <= su_valid & su_rst_b & ~rst;
        su_result    <= {4{su_data ^ stub_prev}};
        if (!su_rst_b) stub_prev <= '0;
        else if (su_valid) stub_prev <= su_data;
    end

    function automatic logic [511:0] line_gen(bit cpx, int idx);
        logic [511:0] v;
        for (int i = 0; i < 16; i++)
            v[32*i +: 32] = cpx ? 32'h8080_8080 : {idx[15:0], 8'(i), 8'h5A ^ 8'(idx)};
        return v;
    endfunction

    function automatic logic [127:0] beat_gen(bit cpx, int b);
        logic [511:0] lv;
        lv = line_gen(cpx, b / 4);
        return lv[128*(b % 4) +: 128];
    endfunction

    // Kept output j comes from beat 64+j (rows 0 and 1 are priming rows).
    function automatic logic [511:0] exp_out(bit cpx, int j);
        logic [127:0] d, p;
        d = beat_gen(cpx, 64 + j);
        p = beat_gen(cpx, 63 + j);
        return {4{d ^ p}};
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input int id);
        string        tag;
        int           lines, beats, outs, dones, occ, post;
        bit           sv_prev, keep_prev, hold, seen_done, pop;
        logic [511:0] hold_data;
        tag = $sformatf("v%0d", id);
        lines = 0; beats = 0; outs = 0; dones = 0; occ = 0; post = 0;
        sv_prev = 0; keep_prev = 0; hold = 0; seen_done = 0;
        hold_data = '0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            start     = (c == 0);
            cfg_rows  = 16'(v.rows);
            in_valid  = (v.iv_mode == 0) ? 1'b1 : (c % 3 == 0);
            in_data   = line_gen(v.cpx, lines);
            out_ready = (v.rdy_mode == 0) ? 1'b1 : (c % 3 == 0);
            #1;
            if (c == 1) begin
                if (v.exp_err) begin
                    chk({tag, ":err_done"}, done, 1);
                    chk({tag, ":err_flag"}, err, 1);
                    chk({tag, ":err_busy"}, busy, 0);
                end else begin
                    chk({tag, ":clr_su_rst_b"}, su_rst_b, 0);
                    chk({tag, ":clr_busy"}, busy, 1);
                    chk({tag, ":clr_err"}, err, 0);
                end
`ifdef SOBEL_CTRL_PERF_EN
                chk({tag, ":perf_stall_zero"}, perf_stall, 0);
                chk({tag, ":perf_starve_zero"}, perf_starve, 0);
`endif
            end
            if (c == 2 && !v.exp_err) chk({tag, ":run_su_rst_b"}, su_rst_b, 1);
            pop = out_valid & out_ready;
            chk({tag, ":out_valid_vs_occ"}, out_valid, (occ > 0));
            if (su_valid) chk({tag, ":issue_rule"}, (occ + int'(sv_prev) - int'(pop) < 2), 1);
            if (hold && out_valid) chk({tag, ":hold_data"}, out_data, hold_data);
            if (pop) begin
                chk({tag, ":out_data"}, out_data, exp_out(v.cpx, outs));
                chk({tag, ":out_last"}, out_last, (outs == v.exp_outs - 1));
                outs++;
            end
            occ = occ + int'(sv_prev & keep_prev) - int'(pop);
            keep_prev = su_valid & (beats >= 64);
            sv_prev   = su_valid;
            if (su_valid) begin
                chk({tag, ":su_data"}, su_data, beat_gen(v.cpx, beats));
                beats++;
            end
            if (in_valid && in_ready) lines++;
            hold      = out_valid & ~out_ready;
            hold_data = out_data;
            if (done) begin
                dones++;
                seen_done = 1;
            end
            if (seen_done) post++;
            if (post >= 4) break;
        end
        in_valid = 1'b0;
        chk({tag, ":lines"}, lines, v.exp_lines);
        chk({tag, ":beats"}, beats, v.exp_beats);
        chk({tag, ":outs"}, outs, v.exp_outs);
        chk({tag, ":done_count"}, dones, 1);
        chk({tag, ":err_end"}, err, v.exp_err);
        chk({tag, ":busy_end"}, busy, 0);
    endtask

    initial begin
        int beats, lines;
        rst = 1'b1; start = 1'b0; cfg_rows = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        //          rows rdy iv cpx lines beats outs err
        vecs[0] = '{3, 0, 0, 1'b0, 24,  96, 32, 1'b0};
        vecs[1] = '{2, 0, 0, 1'b0,  0,   0,  0, 1'b1};
        vecs[2] = '{4, 1, 0, 1'b0, 32, 128, 64, 1'b0};
        vecs[3] = '{4, 0, 0, 1'b1, 32, 128, 64, 1'b0};
        vecs[4] = '{4, 0, 0, 1'b1, 32, 128, 64, 1'b0};
        vecs[5] = '{3, 0, 1, 1'b0, 24,  96, 32, 1'b0};
        vecs[6] = '{0, 0, 0, 1'b0,  0,   0,  0, 1'b1};

        repeat (3) @(negedge clk);
        #1;
        chk("rst:busy", busy, 0);
        chk("rst:done", done, 0);
        chk("rst:err", err, 0);
        chk("rst:in_ready", in_ready, 0);
        chk("rst:su_valid", su_valid, 0);
        chk("rst:su_data", su_data, 0);
        chk("rst:su_rst_b", su_rst_b, 0);
        chk("rst:out_valid", out_valid, 0);
        chk("rst:out_last", out_last, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i], i);
`ifdef SOBEL_CTRL_PERF_EN
            if (i == 5) begin
                chk("perf:starve_nonzero", (perf_starve != 0), 1);
                chk("perf:stall_zero", perf_stall, 0);
            end
`endif
        end

        // Reset in the middle of row 2 of a 4-row frame.
        beats = 0; lines = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            start = (c == 0); cfg_rows = 16'd4;
            in_valid = 1'b1; out_ready = 1'b1;
            in_data = line_gen(1'b0, lines);
            #1;
            if (su_valid) beats++;
            if (in_valid && in_ready) lines++;
            if (beats >= 70) break;
        end
        chk("midrst:reached_row2", (beats >= 70), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst:busy", busy, 0);
        chk("midrst:out_valid", out_valid, 0);
        chk("midrst:in_ready", in_ready, 0);
        chk("midrst:su_valid", su_valid, 0);
        chk("midrst:su_rst_b", su_rst_b, 0);
        chk("midrst:done", done, 0);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst:no_done", done, 0);
        run_frame(vecs[0], 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
